// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: circular FIFO between fetch and decode carrying PC/instruction pairs.
// Supports a synchronous flush for taken branches and an optional empty-queue bypass path.
module inst_fetch_queue #(
  parameter int                 INSTR_W = 32,
  parameter int                 PC_W    = 32,
  parameter int                 DEPTH   = 4,
  parameter int                 BYPASS  = 0,
  parameter logic [INSTR_W-1:0] NOP     = INSTR_W'(32'h00000013)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_flush,
  input  logic                       i_push_valid,
  output logic                       o_push_ready,
  input  logic [PC_W-1:0]            i_push_pc,
  input  logic [INSTR_W-1:0]         i_push_instr,
  output logic                       o_pop_valid,
  input  logic                       i_pop_ready,
  output logic [PC_W-1:0]            o_pop_pc,
  output logic [PC_W-1:0]            o_pop_pc_4,
  output logic [INSTR_W-1:0]         o_pop_instr,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_W-1:0]    r_pc_mem    [DEPTH];
  logic [INSTR_W-1:0] r_instr_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;

  logic          w_full;
  logic          w_empty;
  logic          w_bypass_path;
  logic          w_push_fire;
  logic          w_pop_fire;
  logic          w_store;
  logic          w_take;
  logic [CW-1:0] w_count_nxt;

  assign w_full        = (r_count == CW'(DEPTH));
  assign w_empty       = (r_count == '0);
  assign w_bypass_path = (BYPASS != 0) && w_empty;

  assign o_push_ready = !w_full && !i_flush;
  assign w_push_fire  = i_push_valid && o_push_ready;
  assign w_pop_fire   = o_pop_valid && i_pop_ready;

  // A bypassed entry consumed in the same cycle never touches storage.
  assign w_store = w_push_fire && !(w_bypass_path && w_pop_fire);
  assign w_take  = w_pop_fire && !w_bypass_path;

  always_comb begin
    o_pop_valid = 1'b0;
    o_pop_pc    = '0;
    o_pop_instr = NOP;
    if (!i_flush) begin
      if (w_bypass_path) begin
        o_pop_valid = i_push_valid;
        if (i_push_valid) begin
          o_pop_pc    = i_push_pc;
          o_pop_instr = i_push_instr;
        end
      end else if (!w_empty) begin
        o_pop_valid = 1'b1;
        o_pop_pc    = r_pc_mem[r_rd_ptr];
        o_pop_instr = r_instr_mem[r_rd_ptr];
      end
    end
  end

  assign o_pop_pc_4 = o_pop_pc + PC_W'(4);

  always_comb begin
    w_count_nxt = r_count;
    if (w_store && !w_take) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_store && w_take) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_store) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_take) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  // Payload storage is deliberately unreset; the output mux hides it while empty.
  always_ff @(posedge i_clk) begin
    if (w_store) begin
      r_pc_mem[r_wr_ptr]    <= i_push_pc;
      r_instr_mem[r_wr_ptr] <= i_push_instr;
    end
  end

  assign o_count = r_count;
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed self-checking bench for inst_fetch_queue: one DEPTH=4 instance without bypass
// and one with BYPASS=1, both checked against hand-computed expected values.
module tb_inst_fetch_queue;

  localparam logic [31:0] NOP_I = 32'h00000013;

  logic        clk;
  logic        rstN;

  logic        flush;
  logic        pushValid;
  logic        pushReady;
  logic [31:0] pushPc;
  logic [31:0] pushInstr;
  logic        popValid;
  logic        popReady;
  logic [31:0] popPc;
  logic [31:0] popPc4;
  logic [31:0] popInstr;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  logic        bFlush;
  logic        bPushValid;
  logic        bPushReady;
  logic [31:0] bPushPc;
  logic [31:0] bPushInstr;
  logic        bPopValid;
  logic        bPopReady;
  logic [31:0] bPopPc;
  logic [31:0] bPopPc4;
  logic [31:0] bPopInstr;
  logic [2:0]  bCount;
  logic        bFull;
  logic        bEmpty;

  int errors = 0;
  int checks = 0;

  inst_fetch_queue #(.INSTR_W(32), .PC_W(32), .DEPTH(4), .BYPASS(0)) u_dut (
    .i_clk(clk), .i_rst_n(rstN), .i_flush(flush),
    .i_push_valid(pushValid), .o_push_ready(pushReady),
    .i_push_pc(pushPc), .i_push_instr(pushInstr),
    .o_pop_valid(popValid), .i_pop_ready(popReady),
    .o_pop_pc(popPc), .o_pop_pc_4(popPc4), .o_pop_instr(popInstr),
    .o_count(count), .o_full(full), .o_empty(empty)
  );

  inst_fetch_queue #(.INSTR_W(32), .PC_W(32), .DEPTH(4), .BYPASS(1)) u_byp (
    .i_clk(clk), .i_rst_n(rstN), .i_flush(bFlush),
    .i_push_valid(bPushValid), .o_push_ready(bPushReady),
    .i_push_pc(bPushPc), .i_push_instr(bPushInstr),
    .o_pop_valid(bPopValid), .i_pop_ready(bPopReady),
    .o_pop_pc(bPopPc), .o_pop_pc_4(bPopPc4), .o_pop_instr(bPopInstr),
    .o_count(bCount), .o_full(bFull), .o_empty(bEmpty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] instrOf(input logic [31:0] pc);
    return 32'hA000_0000 | pc;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic pv, input logic [31:0] pc, input logic pr, input logic fl);
    pushValid = pv;
    pushPc    = pc;
    pushInstr = instrOf(pc);
    popReady  = pr;
    flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] drainPcs [4];
    drainPcs[0] = 32'h8;
    drainPcs[1] = 32'hC;
    drainPcs[2] = 32'h10;
    drainPcs[3] = 32'h14;

    rstN = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    bFlush = 1'b0; bPushValid = 1'b0; bPushPc = '0; bPushInstr = '0; bPopReady = 1'b0;
    #3;
    checkOutput("rst_count",      32'(count), 32'd0);
    checkOutput("rst_empty",      32'(empty), 32'd1);
    checkOutput("rst_full",       32'(full), 32'd0);
    checkOutput("rst_pop_valid",  32'(popValid), 32'd0);
    checkOutput("rst_push_ready", 32'(pushReady), 32'd1);
    checkOutput("rst_pop_instr",  popInstr, NOP_I);
    checkOutput("rst_pop_pc",     popPc, 32'h0);
    checkOutput("rst_pop_pc_4",   popPc4, 32'h4);
    @(negedge clk);
    rstN = 1'b1;

    // Fill to DEPTH with decode stalled.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'(i * 4), 1'b0, 1'b0);
      tick();
      checkOutput("fill_head_stable", popPc, 32'h0);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    checkOutput("fill_count",      32'(count), 32'd4);
    checkOutput("fill_full",       32'(full), 32'd1);
    checkOutput("fill_push_ready", 32'(pushReady), 32'd0);
    checkOutput("fill_pop_pc",     popPc, 32'h0);
    checkOutput("fill_pop_pc_4",   popPc4, 32'h4);
    checkOutput("fill_pop_instr",  popInstr, instrOf(32'h0));

    // Push while full with a pop: pop fires, push is held off.
    applyStimulus(1'b1, 32'h99, 1'b1, 1'b0);
    tick();
    checkOutput("full_nopt_count", 32'(count), 32'd3);
    checkOutput("full_nopt_head",  popPc, 32'h4);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("pop2_count", 32'(count), 32'd2);

    // Refill across the pointer wrap.
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h14, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    checkOutput("wrap_count", 32'(count), 32'd4);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      #1;
      checkOutput("drain_valid", 32'(popValid), 32'd1);
      checkOutput("drain_pc",    popPc, drainPcs[i]);
      checkOutput("drain_instr", popInstr, instrOf(drainPcs[i]));
      tick();
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    checkOutput("drain_empty",     32'(empty), 32'd1);
    checkOutput("drain_pop_valid", 32'(popValid), 32'd0);
    checkOutput("drain_pop_instr", popInstr, NOP_I);
    checkOutput("drain_pop_pc_4",  popPc4, 32'h4);

    // Simultaneous push and pop at count=2.
    applyStimulus(1'b1, 32'h20, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h24, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h28, 1'b1, 1'b0);
    tick();
    checkOutput("simul_count", 32'(count), 32'd2);
    checkOutput("simul_head",  popPc, 32'h24);

    // Flush at count=3 with a push offered.
    applyStimulus(1'b1, 32'h2C, 1'b0, 1'b0);
    tick();
    checkOutput("preflush_count", 32'(count), 32'd3);
    applyStimulus(1'b1, 32'h30, 1'b1, 1'b1);
    #1;
    checkOutput("flush_comb_pop_valid",  32'(popValid), 32'd0);
    checkOutput("flush_comb_push_ready", 32'(pushReady), 32'd0);
    checkOutput("flush_comb_pop_instr",  popInstr, NOP_I);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    checkOutput("flush_count",     32'(count), 32'd0);
    checkOutput("flush_pop_valid", 32'(popValid), 32'd0);
    applyStimulus(1'b1, 32'h34, 1'b0, 1'b0);
    tick();
    checkOutput("postflush_count", 32'(count), 32'd1);
    checkOutput("postflush_head",  popPc, 32'h34);

    // Pop on an empty queue must not underflow.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    tick();
    checkOutput("underflow_count", 32'(count), 32'd0);
    applyStimulus(1'b1, 32'h38, 1'b0, 1'b0);
    tick();
    checkOutput("underflow_recover_count", 32'(count), 32'd1);
    checkOutput("underflow_recover_head",  popPc, 32'h38);

    // Asynchronous reset between edges at count=3.
    applyStimulus(1'b1, 32'h3C, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("prereset_count", 32'(count), 32'd3);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("async_rst_count",     32'(count), 32'd0);
    checkOutput("async_rst_pop_valid", 32'(popValid), 32'd0);
    #1;
    rstN = 1'b1;
    applyStimulus(1'b1, 32'h44, 1'b0, 1'b0);
    tick();
    checkOutput("rst_release_count", 32'(count), 32'd1);
    checkOutput("rst_release_head",  popPc, 32'h44);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);

    // Bypass instance: same-cycle forward, nothing stored.
    bPushValid = 1'b1; bPushPc = 32'h40; bPushInstr = 32'h00500093; bPopReady = 1'b1;
    #1;
    checkOutput("byp_pop_valid", 32'(bPopValid), 32'd1);
    checkOutput("byp_pop_pc",    bPopPc, 32'h40);
    checkOutput("byp_pop_instr", bPopInstr, 32'h00500093);
    checkOutput("byp_pop_pc_4",  bPopPc4, 32'h44);
    tick();
    checkOutput("byp_count", 32'(bCount), 32'd0);
    // Bypass with decode stalled stores the entry.
    bPushPc = 32'h50; bPushInstr = 32'h00A00113; bPopReady = 1'b0;
    tick();
    bPushValid = 1'b0;
    #1;
    checkOutput("byp_stall_count", 32'(bCount), 32'd1);
    checkOutput("byp_stall_head",  bPopPc, 32'h50);
    checkOutput("byp_stall_instr", bPopInstr, 32'h00A00113);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 Parameter: INSTR_W, default 32, instruction width in bits.
REQ-002 Parameter: PC_W, default 32, program-counter width in bits.
REQ-003 Parameter: DEPTH, default 4, number of entries; power of two, minimum 2.
REQ-004 Parameter: BYPASS, default 0; when 1, an empty queue forwards push data to pop in the same cycle.
REQ-005 Parameter: NOP, default 32'h00000013, instruction driven on pop_instr whenever pop_valid=0.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 flush  input  1  synchronous discard of all entries (branch/jump taken).
REQ-009 push_valid  input  1  fetch side offers an entry.
REQ-010 push_ready  output  1  queue accepts an entry this cycle.
REQ-011 push_pc  input  PC_W  PC of the offered instruction.
REQ-012 push_instr  input  INSTR_W  offered instruction.
REQ-013 pop_valid  output  1  head entry is available.
REQ-014 pop_ready  input  1  decode side consumes the head (stall when 0).
REQ-015 pop_pc  output  PC_W  PC of the head entry.
REQ-016 pop_pc_4  output  PC_W  pop_pc + 4, modulo 2^PC_W.
REQ-017 pop_instr  output  INSTR_W  head instruction, or NOP.
REQ-018 count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-019 full  output  1  count == DEPTH.
REQ-020 empty  output  1  count == 0.

Function
REQ-021 Push fires when push_valid && push_ready; pop fires when pop_valid && pop_ready.
REQ-022 push_ready = !full && !flush; no push-through when full, even if a pop fires in the same cycle.
REQ-023 With BYPASS=0: pop_valid = !empty; an entry pushed at edge N is poppable from cycle N+1 (1-cycle latency).
REQ-024 With BYPASS=1 and empty: pop_valid = push_valid && !flush, pop outputs mirror push inputs combinationally; if both fire, nothing is stored and count stays 0.
REQ-025 Storage is circular: write pointer and read pointer each wrap from DEPTH-1 to 0.
REQ-026 Push only: count+1. Pop only: count-1. Push and pop simultaneously (not full, not empty): count unchanged, both pointers advance.
REQ-027 Entries pop in push order (strict FIFO); pop_pc and pop_instr stay stable while pop_valid && !pop_ready.
REQ-028 flush=1 at an edge sets count=0 and both pointers to 0; a simultaneous push or pop is ignored; pop_valid=0 in the cycle that follows.
REQ-029 While flush=1, pop_valid=0 combinationally, so no instruction leaks to decode in the flush cycle.
REQ-030 When pop_valid=0: pop_instr=NOP and pop_pc=0, so pop_pc_4=4.
REQ-031 push_valid while full is not an error: the entry is held off, no state changes, and the offering side must keep its data.
REQ-032 Popping never underflows: a pop with pop_valid=0 has no effect.

Reset
REQ-033 reset=0 asynchronously clears count and both pointers, giving empty=1, full=0, pop_valid=0, push_ready=1, pop_instr=NOP, pop_pc=0.
REQ-034 Storage contents need not be reset; outputs must not expose stale contents while empty.
REQ-035 Deassertion of reset mid-stream yields an empty queue; the first push is accepted at the first rising edge after deassertion.

Verification
REQ-036 Fill: DEPTH=4, push PCs 0x0,0x4,0x8,0xC with pop_ready=0 -> count=4, full=1, push_ready=0, pop_pc=0x0, pop_pc_4=0x4.
REQ-037 Drain order and wrap: from the full state, pop 2 then push 0x10 and 0x14 -> pops return 0x8, 0xC, 0x10, 0x14 in that order, then empty=1 and pop_instr=0x00000013.
REQ-038 Simultaneous: count=2, push and pop in the same cycle -> count stays 2 and the head advances by one entry.
REQ-039 Flush: count=3 and flush=1 with push_valid=1 -> the next cycle has count=0, pop_valid=0, and the pushed entry is absent.
REQ-040 Bypass: BYPASS=1, empty, push_valid=1 (pc=0x40, instr=0x00500093), pop_ready=1 -> in the same cycle pop_valid=1, pop_pc=0x40, pop_instr=0x00500093; count stays 0.
REQ-041 Async reset: reset=0 asserted between edges while count=3 -> count=0 and pop_valid=0 immediately, without waiting for a clk edge.
